// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_period_meter_pkg                                            |
// | Purpose  : Shared types and default parameter values for the clock period  |
// |            meter (FSM state encoding, default widths/limits).              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package clk_period_meter_pkg;

  // SEEK: waiting for a reference rising edge; MEASURE: counting a period.
  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_EXP_PERIOD = 20;
  localparam int DEF_TOL        = 1;
  localparam int DEF_LOCK_CNT   = 4;

endpackage
`default_nettype wire

// File: rtl/clk_period_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_period_meter_if                                             |
// | Purpose  : Bundles the enable, the clock under test and the measurement    |
// |            results of the clock period meter.                              |
// | Ports    : en, clk_in          (driven by master)                          |
// |            period, period_valid, locked, too_fast, too_slow (by slave)     |
// |            master = user of the meter, slave = the meter itself            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             en;
  logic             clk_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             too_fast;
  logic             too_slow;

  modport master (
    output en,
    output clk_in,
    input  period,
    input  period_valid,
    input  locked,
    input  too_fast,
    input  too_slow
  );

  modport slave (
    input  en,
    input  clk_in,
    output period,
    output period_valid,
    output locked,
    output too_fast,
    output too_slow
  );

endinterface
`default_nettype wire

// File: rtl/clk_period_meter_sync_rise_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_rise_det                                                   |
// | Purpose  : Two-flop synchronizer for an asynchronous input followed by a   |
// |            history flop; produces a registered one-cycle rise pulse.       |
// | Ports    : clk   - system clock                                            |
// |            reset - asynchronous, active-low reset                          |
// |            d     - asynchronous input                                      |
// |            rise  - one-cycle pulse, registered                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;
  logic rise_q,  rise_d;

  // The rise pulse is registered so that, counted from the clk edge that
  // first samples d high, the pulse is visible two edges later and the
  // consumer's registered response lands on the third.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    rise_d  = sync2_q & ~hist_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_period_meter                                                |
// | Purpose  : Measures the period of a divided clock (clk_in) in system clk   |
// |            cycles, flags too-fast/too-slow periods and a missing clock,    |
// |            and declares lock after LOCK_CNT consecutive in-range periods.  |
// | Ports    : clk   - system clock, all state on rising edge                  |
// |            reset - asynchronous, active-low reset                          |
// |            bus   - clk_period_meter_if.slave:                              |
// |                    en, clk_in (in); period, period_valid, locked,          |
// |                    too_fast, too_slow (out, all registered)                |
// | Params   : WIDTH, EXP_PERIOD, TOL, LOCK_CNT                                |
// |            Legal when 2*EXP_PERIOD < 2**WIDTH and EXP_PERIOD > TOL+2.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
  input  logic              clk,
  input  logic              reset,
  clk_period_meter_if.slave bus
);

  localparam int               GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] LO_LIM   = WIDTH'(EXP_PERIOD - TOL);
  localparam logic [WIDTH-1:0] HI_LIM   = WIDTH'(EXP_PERIOD + TOL);
  // The counter stops at the timeout value, so it can never wrap.
  localparam logic [WIDTH-1:0] TIMEOUT  = WIDTH'(2 * EXP_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  state_t            state_q,    state_d;
  logic [WIDTH-1:0]  cnt_q,      cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0]  period_q,   period_d;
  logic              valid_q,    valid_d;
  logic              locked_q,   locked_d;
  logic              fast_q,     fast_d;
  logic              slow_q,     slow_d;

  logic              rise;
  logic              in_range;

  sync_rise_det u_sync_rise_det (
    .clk   (clk),
    .reset (reset),
    .d     (bus.clk_in),
    .rise  (rise)
  );

  assign in_range = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    good_cnt_d = good_cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    fast_d     = 1'b0;
    slow_d     = 1'b0;

    if (!bus.en) begin
      state_d    = SEEK;
      cnt_d      = '0;
      good_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        SEEK: begin
          // First edge only establishes the reference; nothing to report yet.
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = WIDTH'(1);
          end
        end

        MEASURE: begin
          // An edge arriving on the timeout cycle is still a valid
          // measurement, so the edge branch is tested first.
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = WIDTH'(1);
            if (in_range) begin
              if (good_cnt_q != GOOD_MAX) begin
                good_cnt_d = good_cnt_q + 1'b1;
              end
              locked_d = (good_cnt_d == GOOD_MAX);
            end else begin
              good_cnt_d = '0;
              locked_d   = 1'b0;
              if (cnt_q < LO_LIM) begin
                fast_d = 1'b1;
              end else begin
                slow_d = 1'b1;
              end
            end
          end else if (cnt_q == TIMEOUT) begin
            // clk_in stopped: drop back to SEEK, keep the last period.
            state_d    = SEEK;
            cnt_d      = '0;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            slow_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = SEEK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEEK;
      cnt_q      <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      fast_q     <= 1'b0;
      slow_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      fast_q     <= fast_d;
      slow_q     <= slow_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.too_fast     = fast_q;
  assign bus.too_slow     = slow_q;

endmodule
`default_nettype wire
